// File: rtl/cr_iu_hs_seq_if.sv
// Handshake and micro-op bundle between the hardware-stacking sequencer
// and the IU control / datapath / IFU ifctrl logic.
// The master modport is the sequencer; the slave modport is the IU side.
interface cr_iu_hs_seq_if;

    // Sequence requests and acceptance pulses
    logic        hs_entry_req;
    logic        hs_exit_req;
    logic        hs_entry_ack;
    logic        hs_exit_ack;

    // IU status feeding the sequencer
    logic        iu_ifu_spcu_int_en;
    logic        iu_hs_split_ex_stall;
    logic        iu_yy_xx_flush;

    // Micro-op stream injected into decode
    logic        hs_split_iu_ctrl_inst_vld;
    logic [31:0] hs_split_iu_dp_inst_op;
    logic        hs_split_iu_hs_retire_mask;
    logic        hs_split_iu_unstack_chgflw;

    // IFU issue control
    logic        split_ifctrl_hs_stall;
    logic        split_ifctrl_hs_stall_part;

    modport master (
        input  hs_entry_req,
        input  hs_exit_req,
        input  iu_ifu_spcu_int_en,
        input  iu_hs_split_ex_stall,
        input  iu_yy_xx_flush,
        output hs_entry_ack,
        output hs_exit_ack,
        output hs_split_iu_ctrl_inst_vld,
        output hs_split_iu_dp_inst_op,
        output hs_split_iu_hs_retire_mask,
        output hs_split_iu_unstack_chgflw,
        output split_ifctrl_hs_stall,
        output split_ifctrl_hs_stall_part
    );

    modport slave (
        output hs_entry_req,
        output hs_exit_req,
        output iu_ifu_spcu_int_en,
        output iu_hs_split_ex_stall,
        output iu_yy_xx_flush,
        input  hs_entry_ack,
        input  hs_exit_ack,
        input  hs_split_iu_ctrl_inst_vld,
        input  hs_split_iu_dp_inst_op,
        input  hs_split_iu_hs_retire_mask,
        input  hs_split_iu_unstack_chgflw,
        input  split_ifctrl_hs_stall,
        input  split_ifctrl_hs_stall_part
    );

endinterface

// File: rtl/cr_iu_hs_seq.sv
// Hardware-stacking sequencer: turns an interrupt entry into a stream of
// "addi sp,-48 ; sw x.." micro-ops and an unstacking mret into a stream of
// "lw x.. ; addi sp,+48" micro-ops, stalling the IFU while the stream runs.
// All micro-op outputs decode combinationally from the state and idx
// registers, so a stalled micro-op stays on the bus unchanged.
module cr_iu_hs_seq (
    input  logic           cpuclk,
    input  logic           cpurst_b,
    cr_iu_hs_seq_if.master hs
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STACK   = 2'd1,
        UNSTACK = 2'd2,
        CHGFLW  = 2'd3
    } state_t;

    localparam int          NUM_SLOTS   = 10;
    localparam logic [3:0]  IDX_LAST    = 4'd10;
    localparam logic [31:0] OP_SP_DEC48 = 32'hFD010113;   // addi sp,sp,-48
    localparam logic [31:0] OP_SP_INC48 = 32'h03010113;   // addi sp,sp,48

    // Caller-saved RV32E register held in frame slot k (slot k sits at 4k(sp))
    function automatic logic [4:0] slot_reg(input int k);
        case (k)
            0:       slot_reg = 5'd1;
            1:       slot_reg = 5'd5;
            2:       slot_reg = 5'd6;
            3:       slot_reg = 5'd7;
            default: slot_reg = 5'(k + 6);    // slots 4..9 -> x10..x15
        endcase
    endfunction

    state_t      state_reg;
    logic [3:0]  idx_reg;

    // Per-slot store/load encodings, fixed by the register list
    logic [31:0] sw_tab [NUM_SLOTS];
    logic [31:0] lw_tab [NUM_SLOTS];
    // One-hot slot selects decoded from idx for each stream
    logic [NUM_SLOTS-1:0] sw_sel;
    logic [NUM_SLOTS-1:0] lw_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            localparam logic [11:0] SLOT_IMM = 12'(4 * gi);
            localparam logic [4:0]  SLOT_REG = slot_reg(gi);
            // sw rk, 4k(sp)
            assign sw_tab[gi] = {SLOT_IMM[11:5], SLOT_REG, 5'd2, 3'b010,
                                 SLOT_IMM[4:0], 7'h23};
            // lw rk, 4k(sp)
            assign lw_tab[gi] = {SLOT_IMM, 5'd2, 3'b010, SLOT_REG, 7'h03};
            // Stacking emits slot k at idx k+1 (idx 0 is the sp decrement);
            // unstacking emits slot k at idx k (idx 10 is the sp increment).
            assign sw_sel[gi] = (idx_reg == 4'(gi + 1));
            assign lw_sel[gi] = (idx_reg == 4'(gi));
        end
    endgenerate

    logic        is_idle;
    logic        uop_vld;
    logic        idx_last;
    logic        uop_consume;
    logic        entry_take;
    logic        exit_take;
    logic [31:0] sw_op;
    logic [31:0] lw_op;
    logic [31:0] uop_op;

    assign is_idle     = (state_reg == IDLE);
    assign uop_vld     = (state_reg == STACK) || (state_reg == UNSTACK);
    assign idx_last    = (idx_reg == IDX_LAST);
    assign uop_consume = uop_vld && !hs.iu_hs_split_ex_stall;

    // Entry wins over a simultaneous exit; the exit request stays pending.
    assign entry_take = is_idle && !hs.iu_yy_xx_flush &&
                        hs.hs_entry_req && hs.iu_ifu_spcu_int_en;
    assign exit_take  = is_idle && !hs.iu_yy_xx_flush &&
                        hs.hs_exit_req && !entry_take;

    // Collapse the one-hot slot selects into the store / load words
    always_comb begin
        sw_op = '0;
        lw_op = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (sw_sel[k]) sw_op = sw_tab[k];
            if (lw_sel[k]) lw_op = lw_tab[k];
        end
    end

    // Micro-op word for the current state/idx; zero whenever nothing is valid
    always_comb begin
        uop_op = '0;
        case (state_reg)
            STACK:   uop_op = (idx_reg == 4'd0) ? OP_SP_DEC48 : sw_op;
            UNSTACK: uop_op = idx_last ? OP_SP_INC48 : lw_op;
            default: uop_op = '0;
        endcase
    end

    assign hs.hs_entry_ack               = entry_take;
    assign hs.hs_exit_ack                = exit_take;
    assign hs.hs_split_iu_ctrl_inst_vld  = uop_vld;
    assign hs.hs_split_iu_dp_inst_op     = uop_op;
    // Only the final micro-op retires, standing for the whole sequence
    assign hs.hs_split_iu_hs_retire_mask = uop_vld && !idx_last;
    assign hs.hs_split_iu_unstack_chgflw = (state_reg == CHGFLW);
    assign hs.split_ifctrl_hs_stall      = !is_idle;
    assign hs.split_ifctrl_hs_stall_part = uop_vld && idx_last;

    // Sequencer FSM: state and micro-op index advance on consumption only
    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_reg <= 4'd0;
                    if (entry_take) begin
                        state_reg <= STACK;
                    end else if (exit_take) begin
                        state_reg <= UNSTACK;
                    end
                end
                STACK: begin
                    if (hs.iu_yy_xx_flush) begin
                        state_reg <= IDLE;
                        idx_reg   <= 4'd0;
                    end else if (uop_consume) begin
                        if (idx_last) begin
                            state_reg <= IDLE;
                            idx_reg   <= 4'd0;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                UNSTACK: begin
                    if (hs.iu_yy_xx_flush) begin
                        state_reg <= IDLE;
                        idx_reg   <= 4'd0;
                    end else if (uop_consume) begin
                        if (idx_last) begin
                            state_reg <= CHGFLW;
                            idx_reg   <= 4'd0;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                CHGFLW: begin
                    // Single-cycle redirect pulse; a flush here changes nothing
                    state_reg <= IDLE;
                    idx_reg   <= 4'd0;
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= 4'd0;
                end
            endcase
        end
    end

endmodule
